// File: rtl/esp_spi_pkg.sv
// Shared types and constants for the ESP SPI frame scheduler.
package esp_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SEND,
    DONE
  } state_e;

  localparam logic [7:0] CMD_WRITE_DATA = 8'h02;
  localparam logic [7:0] ESP_ADDR       = 8'h00;
  localparam int         FRAME_BYTES    = 34;
  localparam int         FRAME_BITS     = 256;

  // Byte 0 is the write command, byte 1 the address, then the payload LSB first.
  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] frame,
                                            input logic [5:0]            idx);
    logic [4:0] k;
    k = 5'(idx - 6'd2);
    if (idx == 6'd0)
      return CMD_WRITE_DATA;
    else if (idx == 6'd1)
      return ESP_ADDR;
    else
      return frame[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/esp_spi_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr wins, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int j;
    j           = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      j = (int'(ptr) + off) % NUM_REQ;
      if (!grant_valid && req[j]) begin
        grant[j]    = 1'b1;
        grant_idx   = 3'(j);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/esp_spi_frame_scheduler.sv
// Round-robin scheduler streaming 34-byte write frames into an SPI core.
// Optional write_ack watchdog enabled by defining ESP_SPI_SCHED_TIMEOUT_EN.
module esp_spi_frame_scheduler
  import esp_spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FRAME_BITS-1:0] data,
  output logic [NUM_REQ-1:0]            grant_ack,
  input  logic                          di_req,
  input  logic                          write_ack,
  output logic [7:0]                    spi_byte,
  output logic                          wren,
  output logic                          busy,
  output logic [2:0]                    active_id,
  output logic                          frame_done,
  output logic                          timeout_err
);

  state_e                  state_q, state_d;
  logic [2:0]              ptr_q, ptr_d;
  logic [5:0]              cnt_q, cnt_d;
  logic                    wren_q, wren_d;
  logic [7:0]              byte_q, byte_d;
  logic [NUM_REQ-1:0]      grant_ack_q, grant_ack_d;
  logic                    frame_done_q, frame_done_d;
  logic [2:0]              active_id_q, active_id_d;
  logic                    ack_prev_q;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic                    ack_rise;
  logic [2:0]              next_ptr;
  logic [NUM_REQ-1:0]      arb_grant;
  logic [2:0]              arb_idx;
  logic                    arb_valid;
`ifdef ESP_SPI_SCHED_TIMEOUT_EN
  logic [31:0]             wd_q, wd_d;
  logic                    timeout_err_q, timeout_err_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (req),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign ack_rise = write_ack & ~ack_prev_q;
  assign next_ptr = (active_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : active_id_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    wren_d       = wren_q;
    byte_d       = byte_q;
    grant_ack_d  = '0;
    frame_done_d = 1'b0;
    active_id_d  = active_id_q;
    frame_d      = frame_q;
`ifdef ESP_SPI_SCHED_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) state_d = GRANT;
      end
      // A request dropped between IDLE and GRANT simply returns to IDLE.
      GRANT: begin
        if (arb_valid) begin
          frame_d     = data[arb_idx*FRAME_BITS +: FRAME_BITS];
          grant_ack_d = arb_grant;
          active_id_d = arb_idx;
          cnt_d       = '0;
          state_d     = SEND;
`ifdef ESP_SPI_SCHED_TIMEOUT_EN
          wd_d        = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (wren_q && ack_rise) begin
          wren_d = 1'b0;
`ifdef ESP_SPI_SCHED_TIMEOUT_EN
          wd_d   = '0;
`endif
          if (cnt_q == 6'(FRAME_BYTES - 1)) begin
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end else if (!wren_q && di_req && !ack_rise) begin
          wren_d = 1'b1;
          byte_d = frame_byte(frame_q, cnt_q);
        end
`ifdef ESP_SPI_SCHED_TIMEOUT_EN
        else if (wren_q) begin
          if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
            wren_d        = 1'b0;
            timeout_err_d = 1'b1;
            ptr_d         = next_ptr;
            state_d       = IDLE;
          end else begin
            wd_d = wd_q + 32'd1;
          end
        end
`endif
      end
      DONE: begin
        ptr_d   = next_ptr;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      wren_q       <= 1'b0;
      byte_q       <= '0;
      grant_ack_q  <= '0;
      frame_done_q <= 1'b0;
      active_id_q  <= '0;
      ack_prev_q   <= 1'b0;
      frame_q      <= '0;
`ifdef ESP_SPI_SCHED_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      wren_q       <= wren_d;
      byte_q       <= byte_d;
      grant_ack_q  <= grant_ack_d;
      frame_done_q <= frame_done_d;
      active_id_q  <= active_id_d;
      ack_prev_q   <= write_ack;
      frame_q      <= frame_d;
`ifdef ESP_SPI_SCHED_TIMEOUT_EN
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant_ack  = grant_ack_q;
  assign spi_byte   = byte_q;
  assign wren       = wren_q;
  assign busy       = (state_q != IDLE);
  assign active_id  = active_id_q;
  assign frame_done = frame_done_q;
`ifdef ESP_SPI_SCHED_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_esp_spi_frame_scheduler.sv
// Directed self-checking bench for esp_spi_frame_scheduler with a simple SPI core model.
module tb_esp_spi_frame_scheduler;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*256-1:0] data = '0;
  logic           di_req = 1'b1;
  logic           write_ack = 1'b0;
  logic [N-1:0]   grant_ack;
  logic [7:0]     spi_byte;
  logic           wren;
  logic           busy;
  logic [2:0]     active_id;
  logic           frame_done;
  logic           timeout_err;

  int tests_run = 0;
  int tests_failed = 0;

  int  hold_len = 1;
  bit  never_ack = 1'b0;
  bit  spur_req = 1'b0;
  bit  spur_prev = 1'b0;
  int  ack_cnt = 0;

  logic [7:0]   cap_mem [0:2047];
  int           cap_cnt = 0;
  logic [2:0]   gnt_id [0:63];
  logic [N-1:0] gnt_oh [0:63];
  int           gnt_cnt = 0;
  int           fd_cnt = 0;
  int           to_cnt = 0;
  int           wren_cyc = 0;

  esp_spi_frame_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .data        (data),
    .grant_ack   (grant_ack),
    .di_req      (di_req),
    .write_ack   (write_ack),
    .spi_byte    (spi_byte),
    .wren        (wren),
    .busy        (busy),
    .active_id   (active_id),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  // SPI core model and event monitor, both sampled on the falling edge.
  always @(negedge clock) begin
    if (wren) wren_cyc++;
    if (|grant_ack) begin
      if (gnt_cnt < 64) begin
        gnt_id[gnt_cnt] = active_id;
        gnt_oh[gnt_cnt] = grant_ack;
      end
      gnt_cnt++;
    end
    if (frame_done) fd_cnt++;
    if (timeout_err) to_cnt++;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) write_ack = 1'b0;
    end else if (spur_req && !spur_prev) begin
      write_ack = 1'b1;
      ack_cnt = 1;
    end else if (wren && !write_ack && !never_ack) begin
      write_ack = 1'b1;
      ack_cnt = hold_len;
      if (cap_cnt < 2048) cap_mem[cap_cnt] = spi_byte;
      cap_cnt++;
    end
    spur_prev = spur_req;
  end

  function automatic int cnt_of(input int sel);
    case (sel)
      0: return gnt_cnt;
      1: return fd_cnt;
      2: return cap_cnt;
      default: return to_cnt;
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] base, input int k);
    if (k == 0) return 8'h02;
    if (k == 1) return 8'h00;
    return base + 8'(k - 2);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_frame(input int r, input logic [7:0] base);
    for (int k = 0; k < 32; k++) data[r*256 + k*8 +: 8] = base + 8'(k);
  endtask

  task automatic wait_for(input int sel, input int target, input int budget, input string name);
    int c;
    c = 0;
    while (cnt_of(sel) < target && c < budget) begin
      tick();
      c++;
    end
    tests_run++;
    if (cnt_of(sel) < target) begin
      tests_failed++;
      $display("[TB] FAIL %s: wait expired, count %0d, need %0d", name, cnt_of(sel), target);
    end
  endtask

  task automatic check_frame(input int start, input logic [7:0] base, input string name);
    for (int k = 0; k < 34; k++) begin
      tests_run++;
      if (cap_mem[start+k] !== exp_byte(base, k)) begin
        tests_failed++;
        $display("[TB] FAIL %s byte %0d: got %h, expected %h", name, k, cap_mem[start+k], exp_byte(base, k));
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    tests_run++;
    if ({busy, wren, frame_done, timeout_err} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL %s flags: busy/wren/frame_done/timeout_err=%b, expected 0000", name, {busy, wren, frame_done, timeout_err});
    end
    tests_run++;
    if (spi_byte !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL %s spi_byte: got %h, expected 00", name, spi_byte);
    end
    tests_run++;
    if (grant_ack !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL %s grant_ack: got %b, expected 0000", name, grant_ack);
    end
    tests_run++;
    if (active_id !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL %s active_id: got %0d, expected 0", name, active_id);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    int g0, f0, c0;
    do_reset();
    set_frame(0, 8'h00);
    g0 = gnt_cnt; f0 = fd_cnt; c0 = cap_cnt;
    req = 4'b0001;
    wait_for(0, g0 + 1, 20, "single_grant");
    req = 4'b0000;
    wait_for(1, f0 + 1, 300, "single_done");
    repeat (4) tick();
    tests_run++;
    if (gnt_cnt - g0 != 1 || gnt_oh[g0] !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL single_grant_ack: pulses %0d onehot %b, expected 1 and 0001", gnt_cnt - g0, gnt_oh[g0]);
    end
    tests_run++;
    if (fd_cnt - f0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL single_frame_done: got %0d pulses, expected 1", fd_cnt - f0);
    end
    tests_run++;
    if (cap_cnt - c0 != 34) begin
      tests_failed++;
      $display("[TB] FAIL single_byte_count: got %0d, expected 34", cap_cnt - c0);
    end
    check_frame(c0, 8'h00, "single");
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_busy_after: got %b, expected 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int g0, f0, c0;
    logic [7:0] bases [0:3];
    bases[0] = 8'h10; bases[1] = 8'h40; bases[2] = 8'h70; bases[3] = 8'hA0;
    do_reset();
    for (int r = 0; r < 4; r++) set_frame(r, bases[r]);
    g0 = gnt_cnt; f0 = fd_cnt; c0 = cap_cnt;
    req = 4'b1111;
    wait_for(1, f0 + 8, 1600, "rr_done");
    req = 4'b0000;
    repeat (4) tick();
    tests_run++;
    if (gnt_cnt - g0 != 8) begin
      tests_failed++;
      $display("[TB] FAIL rr_grant_count: got %0d, expected 8", gnt_cnt - g0);
    end
    for (int f = 0; f < 8; f++) begin
      tests_run++;
      if (gnt_id[g0+f] !== 3'(f % 4)) begin
        tests_failed++;
        $display("[TB] FAIL rr_id frame %0d: got %0d, expected %0d", f, gnt_id[g0+f], f % 4);
      end
      tests_run++;
      if (cap_mem[c0 + 34*f + 2] !== bases[f % 4]) begin
        tests_failed++;
        $display("[TB] FAIL rr_payload frame %0d: got %h, expected %h", f, cap_mem[c0 + 34*f + 2], bases[f % 4]);
      end
    end
  endtask

  task automatic test_ack_hold();
    int g0, f0, c0;
    do_reset();
    hold_len = 3;
    di_req = 1'b0;
    set_frame(0, 8'hC0);
    g0 = gnt_cnt; f0 = fd_cnt; c0 = cap_cnt;
    req = 4'b0001;
    wait_for(0, g0 + 1, 20, "hold_grant");
    req = 4'b0000;
    tick();
    spur_req = 1'b1;
    repeat (3) tick();
    spur_req = 1'b0;
    tests_run++;
    if (wren !== 1'b0 || cap_cnt != c0) begin
      tests_failed++;
      $display("[TB] FAIL hold_spurious: wren %b bytes %0d, expected 0 and 0", wren, cap_cnt - c0);
    end
    di_req = 1'b1;
    wait_for(1, f0 + 1, 600, "hold_done");
    repeat (6) tick();
    tests_run++;
    if (cap_cnt - c0 != 34) begin
      tests_failed++;
      $display("[TB] FAIL hold_byte_count: got %0d, expected 34", cap_cnt - c0);
    end
    check_frame(c0, 8'hC0, "hold");
    hold_len = 1;
  endtask

  task automatic test_midframe_reset();
    int g0, f0, c0, fsnap;
    do_reset();
    set_frame(0, 8'h00);
    set_frame(1, 8'h50);
    f0 = fd_cnt; g0 = gnt_cnt;
    req = 4'b0001;
    wait_for(0, g0 + 1, 20, "mid_first_grant");
    req = 4'b0000;
    wait_for(1, f0 + 1, 300, "mid_first_done");
    repeat (3) tick();
    c0 = cap_cnt; g0 = gnt_cnt;
    req = 4'b0010;
    wait_for(0, g0 + 1, 20, "mid_second_grant");
    req = 4'b0000;
    wait_for(2, c0 + 11, 100, "mid_byte10");
    fsnap = fd_cnt;
    reset = 1'b1;
    tick();
    check_idle_outputs("mid_reset");
    reset = 1'b0;
    repeat (3) tick();
    c0 = cap_cnt; g0 = gnt_cnt;
    req = 4'b0011;
    wait_for(0, g0 + 1, 20, "mid_restart_grant");
    req = 4'b0000;
    wait_for(1, fsnap + 1, 300, "mid_restart_done");
    repeat (3) tick();
    tests_run++;
    if (gnt_id[g0] !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_restart_id: got %0d, expected 0", gnt_id[g0]);
    end
    tests_run++;
    if (fd_cnt - fsnap != 1) begin
      tests_failed++;
      $display("[TB] FAIL mid_frame_done: got %0d pulses, expected 1", fd_cnt - fsnap);
    end
    tests_run++;
    if (cap_mem[c0] !== 8'h02 || cap_mem[c0+1] !== 8'h00 || cap_mem[c0+2] !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL mid_restart_bytes: got %h %h %h, expected 02 00 00", cap_mem[c0], cap_mem[c0+1], cap_mem[c0+2]);
    end
  endtask

  task automatic test_data_change();
    int g0, f0, c0;
    do_reset();
    set_frame(0, 8'h33);
    g0 = gnt_cnt; f0 = fd_cnt; c0 = cap_cnt;
    req = 4'b0001;
    wait_for(0, g0 + 1, 20, "change_grant");
    set_frame(0, 8'h99);
    req = 4'b0000;
    wait_for(1, f0 + 1, 300, "change_done");
    repeat (3) tick();
    check_frame(c0, 8'h33, "change");
  endtask

`ifdef ESP_SPI_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int g0, f0, w0, c;
    do_reset();
    never_ack = 1'b1;
    f0 = fd_cnt; w0 = wren_cyc;
    req = 4'b0011;
    c = 0;
    while (timeout_err !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
    tests_run++;
    if (timeout_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_pulse: got %b, expected 1", timeout_err);
    end
    tests_run++;
    if (busy !== 1'b0 || wren !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_idle: busy %b wren %b, expected 0 0", busy, wren);
    end
    tests_run++;
    if (wren_cyc - w0 != 16) begin
      tests_failed++;
      $display("[TB] FAIL timeout_wren_cycles: got %0d, expected 16", wren_cyc - w0);
    end
    never_ack = 1'b0;
    g0 = gnt_cnt;
    wait_for(0, g0 + 1, 20, "timeout_next_grant");
    req = 4'b0000;
    wait_for(1, f0 + 1, 300, "timeout_next_done");
    tests_run++;
    if (gnt_id[g0] !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_next_id: got %0d, expected 1", gnt_id[g0]);
    end
  endtask
`else
  task automatic test_timeout();
    tests_run++;
    if (to_cnt != 0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_tied_low: pulses %0d level %b, expected 0", to_cnt, timeout_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_ack_hold();
    test_midframe_reset();
    test_data_change();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "[TB] aborted");
  end

endmodule
